// File: rtl/uart_cmd_master.sv
// Initiator side of the 5-byte UART command link: sends opcode+arg MSB-first, then
// collects the responder's reply into a 32-bit result or aborts on an inter-byte timeout.
module uart_cmd_master #(
    parameter int RESP_BYTES     = 5,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_rcv,
    input  logic [7:0]  rx_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RESP_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_LOW,
        WAIT_HIGH,
        RECV
    } state_t;

    state_t        state;
    logic [39:0]   shift;
    logic [2:0]    tx_cnt;
    logic [RW-1:0] rx_cnt;
    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            timer       <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shift     <= {cmd_op, cmd_arg};
                        tx_cnt    <= '0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_data  <= shift[39:32];
                        state    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    // tx_ready dropping is the only proof uart_tx took the byte
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        shift    <= {shift[31:0], 8'h00};
                        tx_cnt   <= tx_cnt + 3'd1;
                        if (tx_cnt == 3'd4) begin
                            rx_cnt <= '0;
                            timer  <= '0;
                            state  <= RECV;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (tx_ready) begin
                        state <= SEND;
                    end
                end
                RECV: begin
                    if (rx_rcv) begin
                        if (int'(rx_cnt) < 4) begin
                            rsp_data <= {rsp_data[23:0], rx_data};
                        end
                        rx_cnt <= rx_cnt + 1'b1;
                        timer  <= '0;
                        if (rx_cnt == RW'(RESP_BYTES - 1)) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                            cmd_ready   <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        // partial assembly is left in rsp_data for diagnosis
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master with a small uart_tx handshake model and a scripted responder.
module tb_uart_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_rcv;
    logic [7:0]  rx_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] tx_log[$];
    int  tx_drops = 0;
    int  drop_cyc = 0;
    bit  tx_block = 1'b0;
    int  rsp_cyc = 0;
    bit  got_rsp = 1'b0;
    int  last_rx_cyc = 0;

    uart_cmd_master #(.RESP_BYTES(5), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
        .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_rcv(rx_rcv), .rx_data(rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // uart_tx model: takes the byte, drops tx_ready one cycle later, stays busy 3 cycles
    initial begin
        tx_ready = 1'b1;
        forever begin
            step();
            if (tx_block) begin
                tx_ready = 1'b0;
            end else if (tx_start && tx_ready) begin
                tx_log.push_back(tx_data);
                step();
                tx_ready = 1'b0;
                drop_cyc = cyc;
                tx_drops++;
                repeat (3) @(posedge clk);
                #1;
                tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    function automatic logic [39:0] log_word();
        logic [39:0] w;
        w = '1;
        if (tx_log.size() == 5)
            w = {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]};
        return w;
    endfunction

    task automatic issue(input logic [7:0] op, input logic [31:0] arg);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        tx_log.delete();
        tx_drops = 0;
        cmd_op = op;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_recv();
        int n = 0;
        while (tx_drops < 5 && n < 400) begin
            step();
            n++;
        end
        tests++;
        if (tx_drops < 5) begin
            fails++;
            $display("FAIL wait_recv: tx bytes handed off=%0d required 5", tx_drops);
        end
        step();
    endtask

    task automatic send_reply(input logic [39:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data = v[39-8*i -: 8];
            rx_rcv = 1'b1;
            step();
            rx_rcv = 1'b0;
            last_rx_cyc = cyc;
            if (i < n - 1) repeat (2) step();
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        got_rsp = 1'b0;
        while (n < 400) begin
            if (rsp_valid === 1'b1) begin
                got_rsp = 1'b1;
                rsp_cyc = cyc;
                break;
            end
            step();
            n++;
        end
        tests++;
        if (!got_rsp) begin
            fails++;
            $display("FAIL wait_rsp: rsp_valid never seen within 400 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if ({cmd_ready, busy, tx_start, tx_data, rsp_valid, rsp_data, rsp_timeout} !== {1'b1, 44'h0}) begin
            fails++;
            $display("FAIL reset_state: ready=%b busy=%b start=%b txd=%h vld=%b data=%h to=%b required 1 0 0 00 0 00000000 0",
                     cmd_ready, busy, tx_start, tx_data, rsp_valid, rsp_data, rsp_timeout);
        end
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_const();
        issue(8'h07, 32'h0000_0000);
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL const_busy: busy=%b ready=%b required 1 0", busy, cmd_ready);
        end
        wait_recv();
        tests++;
        if (log_word() !== 40'h07_00_00_00_00) begin
            fails++;
            $display("FAIL const_tx: frame=%h required 0700000000", log_word());
        end
        send_reply(40'h00_00_01_03_00, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'h0000_0103 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL const_rsp: data=%h to=%b ready=%b required 00000103 0 1", rsp_data, rsp_timeout, cmd_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0000_0103) begin
            fails++;
            $display("FAIL const_pulse: vld=%b data=%h required 0 00000103", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_echo();
        issue(8'h01, 32'h1234_5678);
        wait_recv();
        tests++;
        if (log_word() !== 40'h01_12_34_56_78) begin
            fails++;
            $display("FAIL echo_tx: frame=%h required 0112345678", log_word());
        end
        send_reply(40'h12_34_56_78_00, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'h1234_5678 || rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL echo_rsp: data=%h to=%b required 12345678 0", rsp_data, rsp_timeout);
        end
    endtask

    task automatic test_timeout_silent();
        issue(8'h04, 32'h0000_0010);
        wait_recv();
        wait_rsp();
        tests++;
        if (rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || (rsp_cyc - (drop_cyc + 1)) != 100) begin
            fails++;
            $display("FAIL timeout_silent: to=%b data=%h delay=%0d required 1 00000000 100",
                     rsp_timeout, rsp_data, rsp_cyc - (drop_cyc + 1));
        end
    endtask

    task automatic test_timeout_partial();
        issue(8'h04, 32'h0000_0020);
        wait_recv();
        send_reply(40'hAB_CD_00_00_00, 2);
        wait_rsp();
        tests++;
        if (rsp_timeout !== 1'b1 || rsp_data !== 32'h0000_ABCD || (rsp_cyc - last_rx_cyc) != 100) begin
            fails++;
            $display("FAIL timeout_partial: to=%b data=%h delay=%0d required 1 0000abcd 100",
                     rsp_timeout, rsp_data, rsp_cyc - last_rx_cyc);
        end
    endtask

    task automatic test_tx_stall();
        int starts = 0;
        int readies = 0;
        tx_block = 1'b1;
        repeat (3) step();
        tx_log.delete();
        tx_drops = 0;
        cmd_op = 8'h02;
        cmd_arg = 32'hCAFE_F00D;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rx_rcv = (i == 10);
            rx_data = 8'h99;
            step();
            if (tx_start !== 1'b0) starts++;
            if (cmd_ready !== 1'b0) readies++;
        end
        rx_rcv = 1'b0;
        tests++;
        if (starts != 0 || readies != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stall: tx_start cycles=%0d ready cycles=%0d busy=%b required 0 0 1", starts, readies, busy);
        end
        cmd_valid = 1'b0;
        tx_block = 1'b0;
        wait_recv();
        tests++;
        if (log_word() !== 40'h02_CA_FE_F0_0D) begin
            fails++;
            $display("FAIL stall_tx: frame=%h required 02cafef00d", log_word());
        end
        send_reply(40'hDE_AD_BE_EF_55, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'hDEAD_BEEF || rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL stall_rsp: data=%h to=%b required deadbeef 0", rsp_data, rsp_timeout);
        end
    endtask

    task automatic test_back_to_back();
        issue(8'h03, 32'h0102_0304);
        wait_recv();
        send_reply(40'h11_22_33_44_00, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'h1122_3344) begin
            fails++;
            $display("FAIL b2b_first: data=%h required 11223344", rsp_data);
        end
        issue(8'h06, 32'hA5A5_A5A5);
        tests++;
        if (cmd_ready !== 1'b0 || rsp_data !== 32'h0) begin
            fails++;
            $display("FAIL b2b_accept: ready=%b data=%h required 0 00000000", cmd_ready, rsp_data);
        end
        wait_recv();
        tests++;
        if (log_word() !== 40'h06_A5_A5_A5_A5) begin
            fails++;
            $display("FAIL b2b_tx: frame=%h required 06a5a5a5a5", log_word());
        end
        send_reply(40'h77_66_55_44_00, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'h7766_5544 || rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL b2b_rsp: data=%h to=%b required 77665544 0", rsp_data, rsp_timeout);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        int vlds = 0;
        issue(8'h05, 32'h0BAD_BEEF);
        while (tx_log.size() < 3 && n < 200) begin
            step();
            n++;
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({cmd_ready, busy, tx_start, tx_data, rsp_valid, rsp_data, rsp_timeout} !== {1'b1, 44'h0}
            || tx_log.size() != 3) begin
            fails++;
            $display("FAIL reset_mid: bytes=%0d ready=%b busy=%b start=%b txd=%h vld=%b data=%h required 3 1 0 0 00 0 00000000",
                     tx_log.size(), cmd_ready, busy, tx_start, tx_data, rsp_valid, rsp_data);
        end
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b0 || tx_start !== 1'b0) vlds++;
        end
        tests++;
        if (vlds != 0) begin
            fails++;
            $display("FAIL reset_quiet: active cycles=%0d required 0", vlds);
        end
        issue(8'h07, 32'h0000_0001);
        wait_recv();
        tests++;
        if (log_word() !== 40'h07_00_00_00_01) begin
            fails++;
            $display("FAIL reset_restart: frame=%h required 0700000001", log_word());
        end
        send_reply(40'h00_00_00_01_00, 5);
        wait_rsp();
        tests++;
        if (rsp_data !== 32'h0000_0001 || rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp: data=%h to=%b required 00000001 0", rsp_data, rsp_timeout);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_arg = '0;
        rx_rcv = 1'b0;
        rx_data = '0;
        test_reset();
        test_const();
        test_echo();
        test_timeout_silent();
        test_timeout_partial();
        test_tx_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
